// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arc4_pkg
// Purpose  : Shared types for the ARC4 S-array initialisation engine.
//            init_mode_t  - pattern select (IDENTITY, REVERSE, FILL, RSVD)
//            init_state_t - engine state (IDLE, WRITE, VERIFY, DRAIN)
// Revision : 1.0 - initial release
// ============================================================================
package arc4_pkg;

  typedef enum logic [1:0] {
    IDENTITY = 2'd0,
    REVERSE  = 2'd1,
    FILL     = 2'd2,
    RSVD     = 2'd3
  } init_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DRAIN  = 2'd3
  } init_state_t;

endpackage
`default_nettype wire

// File: rtl/s_init_pattern.sv
`default_nettype none
// ============================================================================
// Module   : s_init_pattern
// Purpose  : Combinational pattern generator, pattern(idx, mode, fill).
//            Shared by the write pass and the readback pass so the expected
//            value is always exactly the written value.
// Ports    : idx  [ADDR_W:0]   - word index
//            mode [1:0]        - init_mode_t code (RSVD behaves as IDENTITY)
//            fill [DATA_W-1:0] - constant for FILL mode
//            data [DATA_W-1:0] - pattern word, truncated to DATA_W bits
// Revision : 1.0 - initial release
// ============================================================================
module s_init_pattern
  import arc4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic [ADDR_W:0]   idx,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill,
  output logic [DATA_W-1:0] data
);

  localparam int              IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0] rev_idx;

  assign rev_idx = IDX_LAST - idx;

  always_comb begin
    data = DATA_W'(idx);
    case (init_mode_t'(mode))
      REVERSE: data = DATA_W'(rev_idx);
      FILL:    data = fill;
      default: data = DATA_W'(idx);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/s_init_engine.sv
`default_nettype none
// ============================================================================
// Module   : s_init_engine
// Purpose  : Fills a single-port synchronous RAM with an identity, reverse or
//            constant pattern over DEPTH words, with an optional readback
//            check pass.
// Macro    : S_INIT_VERIFY_EN - builds the VERIFY/DRAIN readback pass and the
//            sticky err flag; when undefined err is constant 0 and rddata is
//            ignored.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            en     - start request, sampled while rdy=1
//            rdy    - idle, able to accept en
//            mode   - pattern select, latched at start
//            fill   - FILL constant, latched at start
//            addr   - RAM address
//            wrdata - RAM write data
//            wren   - RAM write enable
//            rddata - RAM read data (one cycle after addr)
//            err    - sticky readback mismatch, cleared at start
// Revision : 1.0 - initial release
// ============================================================================
module s_init_engine
  import arc4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  input  logic [DATA_W-1:0] rddata,
  output logic              err
);

  // The index is one bit wider than the address so the readback pass can
  // step to DEPTH without wrapping when DEPTH = 2**ADDR_W.
  localparam int               IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  generate
    if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("s_init_engine: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_W");
    end
  endgenerate

  init_state_t       state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [IDX_W-1:0]  pat_idx;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] pat;
  logic              start;

  assign start = (state == ST_IDLE) && en;

  s_init_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_pattern (
    .idx  (pat_idx),
    .mode (mode_q),
    .fill (fill_q),
    .data (pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      fill_q <= '0;
    end else if (start) begin
      mode_q <= mode;
      fill_q <= fill;
    end
  end

`ifdef S_INIT_VERIFY_EN
  logic check;
  logic err_q;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = '0;
    pat_idx   = idx;
    rdy       = 1'b0;
    wren      = 1'b0;
    addr      = '0;
    wrdata    = '0;
`ifdef S_INIT_VERIFY_EN
    check     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        wren    = 1'b1;
        addr    = idx[ADDR_W-1:0];
        wrdata  = pat;
        idx_nxt = idx + IDX_ONE;
        if (idx == IDX_LAST) begin
          idx_nxt   = '0;
`ifdef S_INIT_VERIFY_EN
          state_nxt = ST_VERIFY;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef S_INIT_VERIFY_EN
      // Read data lags the address by one cycle, so compare against the
      // pattern of the previous index; idx=0 has nothing to compare yet.
      ST_VERIFY: begin
        addr    = idx[ADDR_W-1:0];
        pat_idx = idx - IDX_ONE;
        check   = (idx != '0);
        idx_nxt = idx + IDX_ONE;
        if (idx == IDX_LAST) state_nxt = ST_DRAIN;
      end
      // idx has stepped to DEPTH here, so pat_idx is the final word.
      ST_DRAIN: begin
        pat_idx   = idx - IDX_ONE;
        check     = 1'b1;
        state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef S_INIT_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (check && (rddata != pat)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_rddata;
  assign unused_rddata = ^rddata;
  assign err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_s_init_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_s_init_engine
// Purpose  : Self-checking bench for s_init_engine (default parameters).
//            Random pattern runs are checked cycle by cycle and through a RAM
//            model against a reference pattern computed from mode/fill.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s_init_engine;

  localparam int DEPTH = 256;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [1:0] mode;
  logic [7:0] fill;
  logic [7:0] addr;
  logic [7:0] wrdata;
  logic       wren;
  logic [7:0] rddata;
  logic       err;

  logic [7:0] mem [DEPTH];
  logic       corrupt;

  int total = 0;
  int bad   = 0;

  s_init_engine #(
    .ADDR_W (8),
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .mode   (mode),
    .fill   (fill),
    .addr   (addr),
    .wrdata (wrdata),
    .wren   (wren),
    .rddata (rddata),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM; corrupt forces word 7 to read as zero.
  always @(posedge clk) begin
    if (wren) mem[addr] <= wrdata;
    rddata <= (corrupt && addr == 8'd7) ? 8'h00 : mem[addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference pattern: word i of a run with the given mode and fill.
  function automatic logic [7:0] ref_word(input logic [1:0] m, input logic [7:0] f, input int i);
    int v;
    case (m)
      2'd1:    v = DEPTH - 1 - i;
      2'd2:    v = f;
      default: v = i;
    endcase
    return v[7:0];
  endfunction

  // Entered at a negedge with rdy=1; returns at the negedge where rdy is back.
  task automatic do_run(input logic [1:0] m, input logic [7:0] f, input bit keep_en);
    logic [7:0] exp_mem [DEPTH];
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = ref_word(m, f, i);
    en   = 1'b1;
    mode = m;
    fill = f;
    @(posedge clk);                    // start edge T
    @(negedge clk);                    // cycle T+1
    if (!keep_en) en = 1'b0;
    // Mid-run changes must not disturb this run.
    mode = 2'($urandom);
    fill = 8'($urandom);
    chk("err_cleared", err, 1'b0);
    for (int k = 1; k <= DEPTH; k++) begin
      chk($sformatf("w_rdy[%0d]", k), rdy, 1'b0);
      chk($sformatf("w_wren[%0d]", k), wren, 1'b1);
      chk($sformatf("w_addr[%0d]", k), addr, k - 1);
      chk($sformatf("w_data[%0d]", k), wrdata, exp_mem[k-1]);
      @(negedge clk);
    end
`ifdef S_INIT_VERIFY_EN
    for (int k = 1; k <= DEPTH; k++) begin
      chk($sformatf("v_rdy[%0d]", k), rdy, 1'b0);
      chk($sformatf("v_wren[%0d]", k), wren, 1'b0);
      chk($sformatf("v_addr[%0d]", k), addr, k - 1);
      @(negedge clk);
    end
    chk("drain_rdy", rdy, 1'b0);
    chk("drain_wren", wren, 1'b0);
    @(negedge clk);
    chk("verify_err", err, (corrupt && exp_mem[7] != 8'h00) ? 1'b1 : 1'b0);
`endif
    chk("done_rdy", rdy, 1'b1);
    chk("done_wren", wren, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("mem[%0d]", i), mem[i], exp_mem[i]);
  endtask

  initial begin
    bit hit;
    rst_n   = 1'b0;
    en      = 1'b0;
    mode    = 2'd0;
    fill    = 8'd0;
    corrupt = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_wren", wren, 1'b0);
    chk("rst_addr", addr, 8'd0);
    chk("rst_wrdata", wrdata, 8'd0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    // Inputs that toggle while idle without en must not start a run.
    mode = 2'd1;
    @(negedge clk);
    chk("idle_hold_rdy", rdy, 1'b1);
    chk("idle_hold_wren", wren, 1'b0);

    do_run(2'd0, 8'($urandom), 1'b0);
    do_run(2'd1, 8'($urandom), 1'b0);
    chk("rev_mem0", mem[0], 8'd255);
    chk("rev_mem128", mem[128], 8'd127);
    chk("rev_mem255", mem[255], 8'd0);
    do_run(2'd2, 8'hA5, 1'b0);
    for (int r = 0; r < 4; r++) do_run(2'($urandom), 8'($urandom), 1'b0);
    do_run(2'd3, 8'($urandom), 1'b0);

    // Abort a run with reset once addr reaches 100.
    en   = 1'b1;
    mode = 2'd1;
    @(posedge clk);
    @(negedge clk);
    en  = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      if (wren && addr == 8'd100) hit = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reached", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_wren", wren, 1'b0);
    chk("abort_rdy", rdy, 1'b1);
    chk("abort_addr", addr, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_run(2'd0, 8'($urandom), 1'b0);

    // Held en: back-to-back runs with one idle cycle, new mode each time.
    do_run(2'd1, 8'($urandom), 1'b1);
    do_run(2'd2, 8'($urandom), 1'b1);
    do_run(2'd0, 8'($urandom), 1'b0);

`ifdef S_INIT_VERIFY_EN
    corrupt = 1'b1;
    do_run(2'd0, 8'($urandom), 1'b0);
    corrupt = 1'b0;
    do_run(2'd1, 8'($urandom), 1'b0);
`endif

    @(negedge clk);
    chk("final_rdy", rdy, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
